// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for mem_arbiter and its helpers.
package mem_arb_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IRD    = 3'd1;
    localparam logic [2:0] ST_DRD    = 3'd2;
    localparam logic [2:0] ST_DWR    = 3'd3;
    localparam logic [2:0] ST_RMW_RD = 3'd4;
    localparam logic [2:0] ST_RMW_WR = 3'd5;
    localparam logic [3:0] BYTE_EN_FULL = 4'b1111;
    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        IRD    = ST_IRD,
        DRD    = ST_DRD,
        DWR    = ST_DWR,
        RMW_RD = ST_RMW_RD,
        RMW_WR = ST_RMW_WR
    } state_t;
endpackage

// File: rtl/byte_merge.sv
// byte_merge: per-lane select between an old and a new 32-bit word.
//   old_word : word currently held in memory
//   new_word : lane-aligned replacement data
//   en       : lane enables, bit b selects new_word for byte b
//   merged   : resulting word
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  en,
    output logic [31:0] merged
);
    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign merged[8*b +: 8] = en[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter for a single-port word RAM with read-modify-write partial stores.
//   clk, resetN                   : clock, synchronous active-low reset
//   iReq, iAddr, iReady, iData    : instruction-fetch port
//   dReq, dWe, dAddr, dWdata,
//   dByteEn, dReady, dRdata       : load/store port
//   memAddress, memDataIn,
//   memWriteEnable, memDataOut    : RAM port (read data registered, one cycle latency)
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic        iReady,
    output logic [31:0] iData,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    input  logic [3:0]  dByteEn,
    output logic        dReady,
    output logic [31:0] dRdata,
    output logic [31:0] memAddress,
    output logic [31:0] memDataIn,
    output logic        memWriteEnable,
    input  logic [31:0] memDataOut
);
    state_t      state;
    logic        prio_d;
    logic        idle;
    logic        d_win;
    logic        full;
    logic        wr_full;
    logic [31:0] addr_sel;
    logic [31:0] merged;

    byte_merge u_merge (
        .old_word (memDataOut),
        .new_word (dWdata),
        .en       (dByteEn),
        .merged   (merged)
    );

    always_comb begin
        idle     = state == IDLE;
        // data wins alone, or on a tie when it holds priority
        d_win    = dReq & (~iReq | prio_d);
        full     = dByteEn == BYTE_EN_FULL;
        wr_full  = idle & d_win & dWe & full;
        addr_sel = (d_win ? dAddr : iAddr) & ~32'h3;
        // everything is gated by resetN so an interrupted RMW can never write
        memAddress     = !resetN ? 32'h0 :
                         idle && (iReq || dReq) ? addr_sel :
                         state == RMW_RD ? dAddr & ~32'h3 : 32'h0;
        memWriteEnable = resetN & (wr_full | (state == RMW_RD));
        memDataIn      = !resetN ? 32'h0 : wr_full ? dWdata : state == RMW_RD ? merged : 32'h0;
        iReady = resetN & (state == IRD);
        dReady = resetN & (state == DRD || state == DWR || state == RMW_WR);
        iData  = iReady ? memDataOut : 32'h0;
        dRdata = dReady && state == DRD ? memDataOut : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state  <= IDLE;
            prio_d <= 1'b1;
        end else begin
            case (state)
                IDLE: if (iReq || dReq) begin
                    state <= !d_win ? IRD : !dWe ? DRD : full ? DWR : RMW_RD;
                    // the loser of a tie gets priority next time
                    if (iReq && dReq) prio_d <= ~d_win;
                end
                RMW_RD:  state <= RMW_WR;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a registered-read RAM model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        resetN;
    logic        iReq;
    logic [31:0] iAddr;
    logic        iReady;
    logic [31:0] iData;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dByteEn;
    logic        dReady;
    logic [31:0] dRdata;
    logic [31:0] memAddress;
    logic [31:0] memDataIn;
    logic        memWriteEnable;
    logic [31:0] memDataOut;
    logic [31:0] ram [0:255];
    logic        pl_we;
    logic [7:0]  pl_a;
    logic [31:0] pl_d;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .resetN         (resetN),
        .iReq           (iReq),
        .iAddr          (iAddr),
        .iReady         (iReady),
        .iData          (iData),
        .dReq           (dReq),
        .dWe            (dWe),
        .dAddr          (dAddr),
        .dWdata         (dWdata),
        .dByteEn        (dByteEn),
        .dReady         (dReady),
        .dRdata         (dRdata),
        .memAddress     (memAddress),
        .memDataIn      (memDataIn),
        .memWriteEnable (memWriteEnable),
        .memDataOut     (memDataOut)
    );

    // RAM model: read-before-write, data registered one cycle after the address
    always @(posedge clk) begin
        if (pl_we) ram[pl_a] <= pl_d;
        else if (memWriteEnable) ram[memAddress[9:2]] <= memDataIn;
        memDataOut <= ram[memAddress[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next;
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        next();
        pl_we = 1'b0;
    endtask

    task automatic dreq(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        dReq    = 1'b1;
        dWe     = we;
        dAddr   = a;
        dWdata  = wd;
        dByteEn = be;
        #1;
    endtask

    initial begin
        resetN = 1'b0; iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWe = 1'b0;
        dAddr = '0; dWdata = '0; dByteEn = '0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        next();
        next();
        check("rst_iready", {31'b0, iReady}, 32'h0);
        check("rst_dready", {31'b0, dReady}, 32'h0);
        check("rst_we", {31'b0, memWriteEnable}, 32'h0);
        check("rst_addr", memAddress, 32'h0);
        check("rst_din", memDataIn, 32'h0);
        check("rst_idata", iData, 32'h0);
        check("rst_drdata", dRdata, 32'h0);
        resetN = 1'b1;
        preload(8'd4, 32'hDEADBEEF);
        preload(8'd9, 32'h55667788);
        preload(8'd12, 32'hCAFEF00D);

        // fetch only
        iReq = 1'b1; iAddr = 32'h13; #1;
        check("f_addr", memAddress, 32'h10);
        check("f_we0", {31'b0, memWriteEnable}, 32'h0);
        check("f_early", {31'b0, iReady}, 32'h0);
        next();
        check("f_ready", {31'b0, iReady}, 32'h1);
        check("f_data", iData, 32'hDEADBEEF);
        check("f_dready", {31'b0, dReady}, 32'h0);
        iReq = 1'b0;
        next();
        check("f_pulse", {31'b0, iReady}, 32'h0);

        // full store then load
        dreq(1'b1, 32'h20, 32'h12345678, 4'hF);
        check("fs_we", {31'b0, memWriteEnable}, 32'h1);
        check("fs_din", memDataIn, 32'h12345678);
        check("fs_addr", memAddress, 32'h20);
        next();
        check("fs_ready", {31'b0, dReady}, 32'h1);
        check("fs_noread_we", {31'b0, memWriteEnable}, 32'h0);
        check("fs_rdata", dRdata, 32'h0);
        dReq = 1'b0;
        next();
        dreq(1'b0, 32'h20, 32'h0, 4'h0);
        check("ld_addr", memAddress, 32'h20);
        check("ld_we", {31'b0, memWriteEnable}, 32'h0);
        next();
        check("ld_ready", {31'b0, dReady}, 32'h1);
        check("ld_data", dRdata, 32'h12345678);
        dReq = 1'b0;
        next();

        // partial store
        preload(8'd8, 32'hAABBCCDD);
        dreq(1'b1, 32'h22, 32'h00001100, 4'b0010);
        check("ps_addr", memAddress, 32'h20);
        check("ps_we0", {31'b0, memWriteEnable}, 32'h0);
        next();
        check("ps_we1", {31'b0, memWriteEnable}, 32'h1);
        check("ps_din", memDataIn, 32'hAABB11DD);
        check("ps_addr1", memAddress, 32'h20);
        check("ps_early", {31'b0, dReady}, 32'h0);
        next();
        check("ps_ready", {31'b0, dReady}, 32'h1);
        check("ps_we2", {31'b0, memWriteEnable}, 32'h0);
        dReq = 1'b0;
        next();
        check("ps_ram", ram[8], 32'hAABB11DD);

        // store with no lanes enabled rewrites the word unchanged
        dreq(1'b1, 32'h24, 32'hFFFFFFFF, 4'b0000);
        next();
        check("z_we", {31'b0, memWriteEnable}, 32'h1);
        check("z_din", memDataIn, 32'h55667788);
        next();
        check("z_ready", {31'b0, dReady}, 32'h1);
        dReq = 1'b0;
        next();
        check("z_ram", ram[9], 32'h55667788);

        // reset during RMW_RD
        dreq(1'b1, 32'h30, 32'h000000FF, 4'b0001);
        next();
        resetN = 1'b0; #1;
        check("r_we", {31'b0, memWriteEnable}, 32'h0);
        check("r_dready", {31'b0, dReady}, 32'h0);
        next();
        check("r_dready2", {31'b0, dReady}, 32'h0);
        dReq = 1'b0; resetN = 1'b1;
        next();
        check("r_ram", ram[12], 32'hCAFEF00D);
        check("r_addr", memAddress, 32'h0);
        iReq = 1'b1; iAddr = 32'h10;
        next();
        check("r_idle", {31'b0, iReady}, 32'h1);
        iReq = 1'b0;
        next();

        // continuous contention: D, I, D, I...
        iReq = 1'b1; iAddr = 32'h10;
        dreq(1'b0, 32'h20, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("c_dready%0d", k), {31'b0, dReady}, {31'b0, k % 4 == 1});
            check($sformatf("c_iready%0d", k), {31'b0, iReady}, {31'b0, k % 4 == 3});
            if (k % 2 == 0) check($sformatf("c_addr%0d", k), memAddress, k % 4 == 0 ? 32'h20 : 32'h10);
            if (k % 4 == 1) check($sformatf("c_drdata%0d", k), dRdata, 32'hAABB11DD);
            if (k % 4 == 3) check($sformatf("c_idata%0d", k), iData, 32'hDEADBEEF);
            next();
        end
        iReq = 1'b0; dReq = 1'b0;
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port word RAM. It shares the RAM between the core's instruction-fetch port and its load/store port. It turns partial-word stores into read-modify-write sequences, because the RAM only supports full-word writes. It sits between the core and the RAM and has no other masters.

## Interface
Parameters:
- none; all address and data paths are fixed at 32 bits.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `resetN`  in  1  reset, synchronous, active-low.
- `iReq`  in  1  fetch request; held high, with `iAddr` stable, until `iReady`.
- `iAddr`  in  32  fetch byte address; bits [1:0] ignored.
- `iReady`  out  1  one-cycle completion pulse for fetch.
- `iData`  out  32  fetched word; equals `memDataOut` when `iReady`=1, else 0.
- `dReq`  in  1  data request; held high, with all `d*` inputs stable, until `dReady`.
- `dWe`  in  1  1 = store, 0 = load.
- `dAddr`  in  32  data byte address; bits [1:0] ignored.
- `dWdata`  in  32  store data, lane-aligned (byte 0 = bits [7:0]).
- `dByteEn`  in  4  store lane enables; ignored for loads.
- `dReady`  out  1  one-cycle completion pulse for data.
- `dRdata`  out  32  load word; equals `memDataOut` when `dReady`=1 on a load, else 0.
- `memAddress`  out  32  RAM byte address; bits [1:0] forced to 0.
- `memDataIn`  out  32  RAM write data.
- `memWriteEnable`  out  1  RAM write strobe.
- `memDataOut`  in  32  RAM read data; registered, valid the cycle after the address is presented.

## Operation
- States: IDLE, IRD, DRD, DWR, RMW_RD, RMW_WR.
- IDLE, no request: `memAddress` = 0, `memWriteEnable` = 0.
- IDLE, request present: the arbiter picks a winner and drives the winner's address onto `memAddress` combinationally in the same cycle.
  - Fetch wins: next state IRD.
  - Load wins: next state DRD.
  - Store with `dByteEn` = 4'b1111: `memDataIn` = `dWdata`, `memWriteEnable` = 1; next state DWR.
  - Store with any other `dByteEn`, including 0: read only; next state RMW_RD.
- IRD: `iReady` = 1; next state IDLE.
- DRD: `dReady` = 1; next state IDLE.
- DWR: `dReady` = 1; next state IDLE.
- RMW_RD:
  - `memAddress` = `dAddr`.
  - `memDataIn` = merge(`memDataOut`, `dWdata`, `dByteEn`). Each lane takes `dWdata` where its enable is 1, otherwise `memDataOut`.
  - `memWriteEnable` = 1.
  - Next state RMW_WR.
- RMW_WR: `dReady` = 1; next state IDLE.
- `dByteEn` = 0 still performs the write-back; the word is rewritten unchanged.
- Arbitration is round-robin and applies only when `iReq` and `dReq` are both high in IDLE.
  - Priority register `prioD`; reset value 1 (data wins the first tie).
  - On each tie, the loser gets priority for the next tie.
  - A lone requester always wins and does not change `prioD`.
- A requester whose ready pulse fires may keep its req high in the next cycle. That cycle is treated as a new request and is re-arbitrated in IDLE.
- Reset (`resetN` = 0 at a rising edge):
  - State goes to IDLE and `prioD` goes to 1.
  - Any in-flight access is abandoned and no ready is issued for it.
  - While `resetN` = 0, `memWriteEnable`, `iReady` and `dReady` are forced to 0 combinationally. A half-done read-modify-write therefore never writes.

## Timing
- Reset values: `iReady` = `dReady` = `memWriteEnable` = 0; `iData` = `dRdata` = 0; `memAddress` = 0; `memDataIn` = 0.
- Fetch or load: request sampled in IDLE at cycle N; ready at N+1. Back-to-back rate is one access per 2 cycles.
- Full-word store: RAM written at the end of cycle N; `dReady` at N+1.
- Partial store: read at N, write at N+1, `dReady` at N+2.
- A load issued to the same word immediately after a store sees the new data. The RAM write completes before the next IDLE.
- Never more than one RAM access per cycle. `memWriteEnable` is high only in IDLE (full store) or RMW_RD.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding localparams;
  - the `BYTE_EN_FULL` = 4'b1111 constant.
- One combinational sub-module, `byte_merge` (inputs: old word, new word, 4-bit enable; output: merged word). It is reused by later cache work.

## Test plan
- Fetch only: `iAddr` = 0x10 with RAM[4] = 0xDEADBEEF -> `iReady` exactly one cycle later with `iData` = 0xDEADBEEF; `dReady` stays 0.
- Full store then load: store 0x12345678 to 0x20 with `dByteEn` = F, then load 0x20 -> first `dReady` at +1 with no intermediate RAM read; the load returns 0x12345678.
- Partial store: RAM[8] = 0xAABBCCDD; store `dWdata` = 0x00001100 to 0x22 with `dByteEn` = 4'b0010 -> `dReady` at +2; RAM[8] = 0xAABB11DD.
- Contention: `iReq` and `dReq` held high continuously after reset -> grants go D, I, D, I…; each ready pulses every 4 cycles.
- Reset mid-RMW: drop `resetN` during RMW_RD -> no `memWriteEnable`, no `dReady`; RAM word unchanged; state IDLE after release.
- `dByteEn` = 0 store: -> `dReady` at +2; RAM word unchanged.
